// File: rtl/sr_pkg.sv
// Shared types and sizing helpers for the SR command driver.
// Optional readback checking is enabled by defining SR_READBACK_EN.
package sr_pkg;

    // Widest bit index a captured command can carry (supports banks up to 256 bits)
    localparam int unsigned CMD_IDX_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        CHECK = 2'd3
    } state_t;

    typedef struct packed {
        logic [CMD_IDX_W-1:0] idx;
        logic                 val;
    } cmd_t;

    // Counter width able to hold the larger of the pulse/gap lengths
    function automatic int unsigned cnt_w(input int unsigned pulse, input int unsigned gap);
        int unsigned m;
        m = (pulse > gap) ? pulse : gap;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter shared by the PULSE and GAP phases; stops at zero.
module sr_pulse_timer #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] val,
    output logic         done_c
);

    logic [W-1:0] cnt_q;

    // Load takes priority; otherwise count down and hold at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign done_c = (cnt_q == '0);

endmodule

// File: rtl/sr_cmd_driver.sv
// Command-side driver for a bank of SR flip-flops: turns per-bit level requests
// into single registered S/R pulses, never asserting S and R together, and keeps
// a shadow of the bank state. Define SR_READBACK_EN to add a post-pulse Q check.
module sr_cmd_driver
    import sr_pkg::*;
#(
    parameter int unsigned N            = 8,
    parameter int unsigned PULSE_CYCLES = 1,
    parameter int unsigned GAP_CYCLES   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef SR_READBACK_EN
    input  logic [N-1:0]            q_in,
    output logic                    chk_err,
`endif
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [$clog2(N)-1:0]    req_idx,
    input  logic                    req_val,
    input  logic                    req_force,
    output logic [N-1:0]            s_out,
    output logic [N-1:0]            r_out,
    output logic [N-1:0]            shadow_q,
    output logic                    busy
);

    localparam int unsigned IDX_W      = $clog2(N);
    localparam int unsigned CNT_W      = cnt_w(PULSE_CYCLES, GAP_CYCLES);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam bit   HAS_GAP    = (GAP_CYCLES != 0);
`ifdef SR_READBACK_EN
    localparam state_t POST_STATE = CHECK;
`else
    localparam state_t POST_STATE = IDLE;
`endif

    state_t           state_q, state_d;
    cmd_t             cmd_q, cmd_d;
    logic [N-1:0]     shadow_d, s_d, r_d;
    logic [N-1:0]     req_mask, cmd_mask;
    logic             idx_ok, cur_bit;
    logic             tmr_load, tmr_done_c;
    logic [CNT_W-1:0] tmr_val;
`ifdef SR_READBACK_EN
    logic             chk_err_d;
`endif

    // One-hot decodes of the incoming and captured indices
    assign req_mask = N'(1) << req_idx;
    assign cmd_mask = N'(1) << cmd_q.idx;
    assign idx_ok   = (32'(req_idx) < N);
    assign cur_bit  = |(shadow_q & req_mask);

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);

    sr_pulse_timer #(.W(CNT_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .val    (tmr_val),
        .done_c (tmr_done_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, pulse and shadow update logic
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        shadow_d = shadow_q;
        s_d      = '0;
        r_d      = '0;
        tmr_load = 1'b0;
        tmr_val  = '0;
`ifdef SR_READBACK_EN
        chk_err_d = chk_err;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid && idx_ok && ((cur_bit != req_val) || req_force)) begin
                    cmd_d.idx = CMD_IDX_W'(req_idx);
                    cmd_d.val = req_val;
                    s_d       = req_val ? req_mask : '0;
                    r_d       = req_val ? '0 : req_mask;
                    state_d   = PULSE;
                    tmr_load  = 1'b1;
                    tmr_val   = PULSE_LOAD;
                end
            end
            PULSE: begin
                if (tmr_done_c) begin
                    shadow_d = cmd_q.val ? (shadow_q | cmd_mask) : (shadow_q & ~cmd_mask);
                    if (HAS_GAP) begin
                        state_d  = GAP;
                        tmr_load = 1'b1;
                        tmr_val  = GAP_LOAD;
                    end else begin
                        state_d = POST_STATE;
                    end
                end else begin
                    s_d = s_out;
                    r_d = r_out;
                end
            end
            GAP: begin
                if (tmr_done_c) begin
                    state_d = POST_STATE;
                end
            end
            CHECK: begin
`ifdef SR_READBACK_EN
                if ((|(q_in & cmd_mask)) != cmd_q.val) begin
                    chk_err_d = 1'b1;
                end
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs, captured command and shadow state
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q    <= '0;
            s_out    <= '0;
            r_out    <= '0;
            shadow_q <= '0;
`ifdef SR_READBACK_EN
            chk_err  <= 1'b0;
`endif
        end else begin
            cmd_q    <= cmd_d;
            s_out    <= s_d;
            r_out    <= r_d;
            shadow_q <= shadow_d;
`ifdef SR_READBACK_EN
            chk_err  <= chk_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Bench for sr_cmd_driver: instance A (N=8,P=1,G=1) with a scoreboarded model,
// instance B (N=6,P=3,G=0) for multi-cycle pulses and out-of-range indices.
module tb_sr_cmd_driver;

`ifdef SR_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif
    localparam int LAT_A = 1 + 1 + RB;

    logic       clk = 1'b0;
    int         total = 0;
    int         bad = 0;

    logic       rst_a = 1'b0, v_a = 1'b0, val_a = 1'b0, force_a = 1'b0, ready_a, busy_a;
    logic [2:0] idx_a = '0;
    logic [7:0] s_a, r_a, sh_a;
    logic       rst_b = 1'b0, v_b = 1'b0, val_b = 1'b0, force_b = 1'b0, ready_b, busy_b;
    logic [2:0] idx_b = '0;
    logic [5:0] s_b, r_b, sh_b;
`ifdef SR_READBACK_EN
    logic [7:0] flip_a = '0;
    logic [7:0] q_a;
    logic [5:0] q_b;
    logic       err_a, err_b;
    assign q_a = sh_a ^ flip_a;
    assign q_b = sh_b;
`endif

    typedef struct { logic [7:0] s; logic [7:0] r; } exp_t;
    exp_t       sbq[$];
    logic [7:0] m_sh = '0;
    int         m_left = 0;

    always #5 clk = ~clk;

    sr_cmd_driver #(.N(8), .PULSE_CYCLES(1), .GAP_CYCLES(1)) u_a (
        .clk(clk), .rst(rst_a),
`ifdef SR_READBACK_EN
        .q_in(q_a), .chk_err(err_a),
`endif
        .req_valid(v_a), .req_ready(ready_a), .req_idx(idx_a), .req_val(val_a),
        .req_force(force_a), .s_out(s_a), .r_out(r_a), .shadow_q(sh_a), .busy(busy_a)
    );

    sr_cmd_driver #(.N(6), .PULSE_CYCLES(3), .GAP_CYCLES(0)) u_b (
        .clk(clk), .rst(rst_b),
`ifdef SR_READBACK_EN
        .q_in(q_b), .chk_err(err_b),
`endif
        .req_valid(v_b), .req_ready(ready_b), .req_idx(idx_b), .req_val(val_b),
        .req_force(force_b), .s_out(s_b), .r_out(r_b), .shadow_q(sh_b), .busy(busy_b)
    );

    // Count a comparison and report it if it differs
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One cycle on A: model predicts accept, scoreboard holds the expected pulse
    task automatic step_a(input logic v, input logic [2:0] idx, input logic val, input logic frc);
        exp_t e;
        bit   fire;
        v_a = v; idx_a = idx; val_a = val; force_a = frc;
        fire = v && (m_left == 0) && ((m_sh[idx] != val) || frc);
        if (fire) begin
            e.s = val ? (8'h01 << idx) : 8'h00;
            e.r = val ? 8'h00 : (8'h01 << idx);
            sbq.push_back(e);
            m_sh[idx] = val;
        end
        @(posedge clk); #1;
        if (fire) m_left = LAT_A;
        else if (m_left > 0) m_left--;
        if (fire || ((s_a | r_a) != 8'h00)) begin
            if (sbq.size() == 0) begin
                check("a_unexpected_pulse", 32'(s_a | r_a), 32'h0);
            end else begin
                e = sbq.pop_front();
                check("a_s_pulse", 32'(s_a), 32'(e.s));
                check("a_r_pulse", 32'(r_a), 32'(e.r));
            end
        end
        check("a_ready", 32'(ready_a), 32'(m_left == 0));
        check("a_busy", 32'(busy_a), 32'(m_left != 0));
        check("a_excl", 32'(s_a & r_a), 32'h0);
        check("a_onehot", 32'($countones(s_a | r_a) <= 1), 32'h1);
        if (m_left == 0) check("a_shadow", 32'(sh_a), 32'(m_sh));
        v_a = 1'b0;
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0;
        m_sh = '0; m_left = 0; sbq.delete();
        check("a_rst_s", 32'(s_a), 32'h0);
        check("a_rst_r", 32'(r_a), 32'h0);
        check("a_rst_shadow", 32'(sh_a), 32'h0);
        check("a_rst_busy", 32'(busy_a), 32'h0);
        check("a_rst_ready", 32'(ready_a), 32'h1);
    endtask

    // One cycle on B; inputs stay as driven
    task automatic step_b(input logic v, input logic [2:0] idx, input logic val, input logic frc);
        v_b = v; idx_b = idx; val_b = val; force_b = frc;
        @(posedge clk); #1;
        check("b_excl", 32'(s_b & r_b), 32'h0);
    endtask

    initial begin
        // Instance B held in reset while A runs
        rst_b = 1'b1;
        reset_a();

        // Single set of bit 3: one-cycle S pulse, one gap cycle, then ready
        step_a(1'b1, 3'd3, 1'b1, 1'b0);
        check("t2_s", 32'(s_a), 32'h08);
        check("t2_r", 32'(r_a), 32'h00);
        step_a(1'b0, 3'd0, 1'b0, 1'b0);
        check("t2_s_end", 32'(s_a), 32'h00);
        check("t2_gap_busy", 32'(busy_a), 32'h1);
        for (int i = 0; i < LAT_A - 1; i++) step_a(1'b0, 3'd0, 1'b0, 1'b0);
        check("t2_ready", 32'(ready_a), 32'h1);
        check("t2_shadow", 32'(sh_a), 32'h08);

        // Redundant set dropped; forced set pulses
        step_a(1'b1, 3'd3, 1'b1, 1'b0);
        check("t3_nopulse", 32'(s_a | r_a), 32'h0);
        check("t3_ready", 32'(ready_a), 32'h1);
        step_a(1'b1, 3'd3, 1'b1, 1'b1);
        check("t3_force_s", 32'(s_a), 32'h08);
        for (int i = 0; i < LAT_A; i++) step_a(1'b0, 3'd0, 1'b0, 1'b0);

        // Random command stream against the model
        for (int n = 0; n < 2000; n++) begin
            step_a(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
        end
        for (int i = 0; i < LAT_A; i++) step_a(1'b0, 3'd0, 1'b0, 1'b0);
        check("rand_final_shadow", 32'(sh_a), 32'(m_sh));

`ifdef SR_READBACK_EN
        check("rb_no_err", 32'(err_a), 32'h0);
        flip_a = 8'h04;
        step_a(1'b1, 3'd2, 1'b1, 1'b1);
        for (int i = 0; i < LAT_A; i++) step_a(1'b0, 3'd0, 1'b0, 1'b0);
        check("rb_err_set", 32'(err_a), 32'h1);
        flip_a = 8'h00;
        repeat (3) step_a(1'b0, 3'd0, 1'b0, 1'b0);
        check("rb_err_sticky", 32'(err_a), 32'h1);
        reset_a();
        check("rb_err_cleared", 32'(err_a), 32'h0);
`endif

        // Instance B: release reset
        @(posedge clk); #1;
        rst_b = 1'b0;
        check("b_rst_ready", 32'(ready_b), 32'h1);
        check("b_rst_shadow", 32'(sh_b), 32'h0);

        // Out-of-range indices are dropped
        step_b(1'b1, 3'd6, 1'b1, 1'b1);
        check("t5_idx6_ready", 32'(ready_b), 32'h1);
        check("t5_idx6_sr", 32'(s_b | r_b), 32'h0);
        step_b(1'b1, 3'd7, 1'b0, 1'b1);
        check("t5_idx7_busy", 32'(busy_b), 32'h0);
        check("t5_idx7_sr", 32'(s_b | r_b), 32'h0);

        // Set bit 5: three-cycle S pulse, no gap
        step_b(1'b1, 3'd5, 1'b1, 1'b0);
        check("b_set_s0", 32'(s_b), 32'h20);
        v_b = 1'b0;
        for (int i = 1; i < 3; i++) begin
            step_b(1'b0, 3'd0, 1'b0, 1'b0);
            check("b_set_s", 32'(s_b), 32'h20);
        end
        step_b(1'b0, 3'd0, 1'b0, 1'b0);
        check("b_set_end", 32'(s_b | r_b), 32'h0);
        check("b_set_ready", 32'(ready_b), 32'(RB == 0));
        if (RB != 0) step_b(1'b0, 3'd0, 1'b0, 1'b0);
        check("b_set_shadow", 32'(sh_b), 32'h20);

        // Back-to-back clear then set of bit 5; inputs change mid-pulse
        step_b(1'b1, 3'd5, 1'b0, 1'b0);
        check("t4_r0", 32'(r_b), 32'h20);
        check("t4_s0", 32'(s_b), 32'h00);
        for (int i = 1; i < 3; i++) begin
            step_b(1'b1, 3'd5, 1'b1, 1'b0);
            check("t4_r", 32'(r_b), 32'h20);
            check("t4_r_no_s", 32'(s_b), 32'h00);
        end
        step_b(1'b1, 3'd5, 1'b1, 1'b0);
        check("t4_between", 32'(s_b | r_b), 32'h0);
        if (RB != 0) step_b(1'b1, 3'd5, 1'b1, 1'b0);
        check("t4_clr_shadow", 32'(sh_b), 32'h00);
        for (int i = 0; i < 3; i++) begin
            step_b(1'b1, 3'd5, 1'b1, 1'b0);
            check("t4_s", 32'(s_b), 32'h20);
            check("t4_s_no_r", 32'(r_b), 32'h00);
        end
        v_b = 1'b0;
        for (int i = 0; i < 10 && !ready_b; i++) step_b(1'b0, 3'd0, 1'b0, 1'b0);
        check("t4_idle", 32'(ready_b), 32'h1);
        check("t4_shadow", 32'(sh_b), 32'h20);

        // Reset in the middle of a pulse
        step_b(1'b1, 3'd2, 1'b1, 1'b0);
        check("t1_s_start", 32'(s_b), 32'h04);
        v_b = 1'b0;
        step_b(1'b0, 3'd0, 1'b0, 1'b0);
        check("t1_s_mid", 32'(s_b), 32'h04);
        rst_b = 1'b1;
        step_b(1'b0, 3'd0, 1'b0, 1'b0);
        check("t1_rst_s", 32'(s_b), 32'h0);
        check("t1_rst_r", 32'(r_b), 32'h0);
        check("t1_rst_shadow", 32'(sh_b), 32'h0);
        check("t1_rst_busy", 32'(busy_b), 32'h0);
        step_b(1'b0, 3'd0, 1'b0, 1'b0);
        rst_b = 1'b0;
        check("t1_rst_ready", 32'(ready_b), 32'h1);
        step_b(1'b0, 3'd0, 1'b0, 1'b0);
        check("t1_after_sr", 32'(s_b | r_b), 32'h0);
        check("t1_after_busy", 32'(busy_b), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
